code_sender: RTL and testbench

- Bit-serial transmitter for the team's push-button sequence-lock receiver.
- Latches a CODE_LEN-bit code on start and emits it MSB first on bit_out.
- Marks each bit with an active-low press_n strobe; the receiver samples bit_out on the falling edge of press_n.
- Paced by a tick_en pulse from the clock divider, so it can replace a human operator (SW[0] plus KEY[0]) in bench and board self-test.

---
 rtl/code_sender.sv | 166 ++++++++++++++++
 tb/tb_code_sender.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_sender.sv
// Bit-serial code transmitter for the push-button sequence-lock receiver.
// Sends a latched code MSB first, each bit marked by an active-low press_n strobe paced by tick_en.
module code_sender #(
    parameter int CODE_LEN    = 7,
    parameter int SETUP_TICKS = 1,
    parameter int PRESS_TICKS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_LEN-1:0] code,
    output logic                bit_out,
    output logic                press_n,
    output logic                busy,
    output logic                done,
    output logic [3:0]          bit_idx
);

    localparam int MAX_TICKS = (SETUP_TICKS > PRESS_TICKS) ? SETUP_TICKS : PRESS_TICKS;
    localparam int CNT_W     = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TICKS - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_TICKS - 1);
    localparam logic [3:0]       LAST_IDX   = 4'(CODE_LEN - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_PRESS   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_r,    state_s;
    logic [CODE_LEN-1:0] shift_r,    shift_s;
    logic [CNT_W-1:0]    tick_cnt_r, tick_cnt_s;
    logic                bit_out_r,  bit_out_s;
    logic                press_n_r,  press_n_s;
    logic                busy_r,     busy_s;
    logic                done_r,     done_s;
    logic [3:0]          bit_idx_r,  bit_idx_s;

    // Next-state and next-output computation; abort in any active state takes priority over ticks.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        tick_cnt_s = tick_cnt_r;
        bit_out_s  = bit_out_r;
        press_n_s  = press_n_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bit_idx_s  = bit_idx_r;

        if (abort && (state_r != ST_IDLE)) begin
            state_s    = ST_IDLE;
            tick_cnt_s = '0;
            press_n_s  = 1'b1;
            busy_s     = 1'b0;
            bit_idx_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    press_n_s = 1'b1;
                    if (start) begin
                        shift_s    = code;
                        bit_out_s  = code[CODE_LEN-1];
                        bit_idx_s  = 4'd0;
                        busy_s     = 1'b1;
                        tick_cnt_s = '0;
                        state_s    = ST_SETUP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    if (tick_en) begin
                        if (tick_cnt_r == SETUP_LAST) begin
                            tick_cnt_s = '0;
                            press_n_s  = 1'b0;
                            state_s    = ST_PRESS;
                        end else begin
                            tick_cnt_s = tick_cnt_r + 1'b1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                end

                ST_PRESS: begin
                    if (tick_en) begin
                        if (tick_cnt_r == PRESS_LAST) begin
                            tick_cnt_s = '0;
                            press_n_s  = 1'b1;
                            state_s    = ST_RELEASE;
                        end else begin
                            tick_cnt_s = tick_cnt_r + 1'b1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                end

                // Data stays put for one full tick after the strobe rises before the next bit appears.
                ST_RELEASE: begin
                    if (tick_en) begin
                        if (bit_idx_r == LAST_IDX) begin
                            done_s  = 1'b1;
                            state_s = ST_DONE;
                        end else begin
                            shift_s   = {shift_r[CODE_LEN-2:0], 1'b0};
                            bit_out_s = shift_r[CODE_LEN-2];
                            bit_idx_s = bit_idx_r + 4'd1;
                            state_s   = ST_SETUP;
                        end
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end

                ST_DONE: begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end

                default: begin
                    state_s    = ST_IDLE;
                    tick_cnt_s = '0;
                    press_n_s  = 1'b1;
                    busy_s     = 1'b0;
                    bit_idx_s  = 4'd0;
                end
            endcase
        end
    end

    // State and output registers; async reset releases press_n without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            tick_cnt_r <= '0;
            bit_out_r  <= 1'b0;
            press_n_r  <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bit_idx_r  <= 4'd0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            tick_cnt_r <= tick_cnt_s;
            bit_out_r  <= bit_out_s;
            press_n_r  <= press_n_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bit_idx_r  <= bit_idx_s;
        end
    end

    assign bit_out = bit_out_r;
    assign press_n = press_n_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign bit_idx = bit_idx_r;

endmodule

// File: tb/tb_code_sender.sv
// Scoreboard bench for code_sender: default 7-bit instance with tick every 4 clks,
// plus a 4-bit instance with tick_en tied high.
module tb_code_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en = 1'b0;
    logic       start, abort;
    logic [6:0] code;
    logic       bit_out, press_n, busy, done;
    logic [3:0] bit_idx;

    logic       tick4 = 1'b1;
    logic       start4, abort4;
    logic [3:0] code4;
    logic       bit_out4, press_n4, busy4, done4;
    logic [3:0] bit_idx4;

    always #5 clk = ~clk;

    code_sender u_dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .abort(abort), .code(code),
        .bit_out(bit_out), .press_n(press_n), .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    code_sender #(.CODE_LEN(4), .SETUP_TICKS(1), .PRESS_TICKS(2)) u_dut4 (
        .clk(clk), .rst(rst), .tick_en(tick4), .start(start4), .abort(abort4), .code(code4),
        .bit_out(bit_out4), .press_n(press_n4), .busy(busy4), .done(done4), .bit_idx(bit_idx4)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tick generator: one pulse every 4 clks, phase re-aligned on request so the tick lands 4 clks after start.
    int div = 0;
    bit sync_req = 1'b0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (sync_req) div = 0;
        else div = (div + 1) % 4;
        tick_en = (div == 3);
    end

    // Scoreboard state
    logic exp_q[$];
    logic exp4_q[$];
    logic e_bit, e4_bit;
    logic [6:0] rx_code;
    int rx_state = 0;
    int edges = 0, edges4 = 0;
    int start_cyc = 0, start4_cyc = 0;
    int done_seen = 0, done4_seen = 0;
    int low_len = 0, since_chg = 100, since_rise = 100;
    bit chk_len = 1'b1, done_expected = 1'b0, abort_expected = 1'b0;
    logic prev_press = 1'b1, prev_bit = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    logic prev_press4 = 1'b1;

    // Monitor for the default instance
    always @(negedge clk) begin
        if (!rst) begin
            prev_press = 1'b1; prev_bit = bit_out; prev_busy = 1'b0; prev_done = 1'b0;
            since_chg = 100; since_rise = 100; low_len = 0;
        end else begin
            since_chg++;
            since_rise++;
            if (bit_out !== prev_bit) begin
                if (!press_n && !prev_press) check("bit_stable_while_low", bit_out, prev_bit);
                else if (press_n) check("bit_hold_after_rise", (since_rise >= 4) ? 1 : 0, 1);
                since_chg = 0;
            end
            if (prev_press && !press_n) begin
                edges++;
                low_len = 1;
                check("bit_setup_before_fall", (since_chg >= 4) ? 1 : 0, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_press", 1, 0);
                end else begin
                    e_bit = exp_q.pop_front();
                    check("bit_at_press", bit_out, e_bit);
                end
                if (rx_state < 7 && bit_out == rx_code[6 - rx_state]) rx_state++;
                else rx_state = 0;
            end else if (!press_n) begin
                low_len++;
            end
            if (!prev_press && press_n) begin
                since_rise = 0;
                if (chk_len) check("press_low_clks", low_len, 8);
            end
            if (done) begin
                check("done_expected", done_expected, 1);
                if (done_expected) begin
                    check("done_latency", cyc - start_cyc, 112);
                    check("falling_edges", edges, 7);
                    check("receiver_state", rx_state, 7);
                    check("queue_empty_at_done", exp_q.size(), 0);
                end
                done_expected = 1'b0;
                done_seen++;
            end
            if (prev_busy && !busy && !abort_expected) check("busy_drop_after_done", prev_done, 1);
            prev_press = press_n; prev_bit = bit_out; prev_busy = busy; prev_done = done;
        end
    end

    // Monitor for the tick-high 4-bit instance
    always @(negedge clk) begin
        if (rst) begin
            if (prev_press4 && !press_n4) begin
                edges4++;
                if (exp4_q.size() == 0) begin
                    check("unexpected_press4", 1, 0);
                end else begin
                    e4_bit = exp4_q.pop_front();
                    check("bit4_at_press", bit_out4, e4_bit);
                end
            end
            if (done4) begin
                check("done4_latency", cyc - start4_cyc, 16);
                check("falling_edges4", edges4, 4);
                done4_seen++;
            end
        end
        prev_press4 = press_n4;
    end

    task automatic send(input logic [6:0] c, input bit with_abort);
        @(posedge clk);
        #2;
        start = 1'b1; code = c; abort = with_abort; sync_req = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(c[6 - i]);
        rx_code = c; rx_state = 0; edges = 0; done_expected = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        #1;
        start = 1'b0; abort = 1'b0; sync_req = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_bit_out", bit_out, c[6]);
        check("accept_press_n", press_n, 1);
        check("accept_bit_idx", bit_idx, 0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int snap;
        snap = done_seen;
        n = 0;
        while (done_seen == snap && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", (done_seen != snap) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_press_on(input int idx, input int budget);
        int n;
        n = 0;
        while (!(bit_idx == 4'(idx) && press_n == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("press_reached", (n < budget) ? 1 : 0, 1);
    endtask

    int edges_snap;
    int n4;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; code = 7'd0;
        start4 = 1'b0; abort4 = 1'b0; code4 = 4'd0;
        #23;
        check("rst_press_n", press_n, 1);
        check("rst_bit_out", bit_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bit_idx", bit_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Plain transfer of 1010100
        send(7'b1010100, 1'b0);
        wait_done(300);

        // Second start mid-transfer with zero code must not disturb the sequence
        send(7'b1010100, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        start = 1'b1; code = 7'h00;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("busy_after_stray_start", busy, 1);
        wait_done(300);

        // Abort while bit 3 is pressed, then resend the full code
        send(7'b1010100, 1'b0);
        wait_press_on(3, 300);
        chk_len = 1'b0; abort_expected = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_press_n", press_n, 1);
        check("abort_busy", busy, 0);
        check("abort_bit_idx", bit_idx, 0);
        check("abort_done", done, 0);
        #1;
        abort = 1'b0;
        exp_q.delete();
        done_expected = 1'b0;
        repeat (10) @(posedge clk);
        abort_expected = 1'b0; chk_len = 1'b1;
        send(7'b1010100, 1'b0);
        wait_done(300);

        // start and abort together in IDLE: start wins
        send(7'b0110011, 1'b1);
        wait_done(300);

        // Async reset while press_n is low
        send(7'b1010100, 1'b0);
        wait_press_on(1, 300);
        chk_len = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        done_expected = 1'b0;
        #1;
        check("async_rst_press_n", press_n, 1);
        check("async_rst_bit_out", bit_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_bit_idx", bit_idx, 0);
        edges_snap = edges;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no_edges_after_rst", edges, edges_snap);
        check("idle_after_rst", busy, 0);
        chk_len = 1'b1;

        // tick_en tied high, 4-bit code 1001
        @(posedge clk);
        #2;
        start4 = 1'b1; code4 = 4'b1001;
        exp4_q.push_back(1'b1); exp4_q.push_back(1'b0);
        exp4_q.push_back(1'b0); exp4_q.push_back(1'b1);
        edges4 = 0;
        @(posedge clk);
        #1;
        start4_cyc = cyc;
        #1;
        start4 = 1'b0;
        n4 = 0;
        while (done4_seen == 0 && n4 < 100) begin
            @(negedge clk);
            n4++;
        end
        check("done4_within_budget", done4_seen, 1);
        check("queue4_empty", exp4_q.size(), 0);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
